// File: rtl/dfr_axi_pkg.sv
// rtl/dfr_axi_pkg.sv - shared types and response codes for the DFR AXI4-Lite command master
package dfr_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } axi_master_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - free-running up counter with synchronous clear and enable
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI4-Lite master driven by a read/write command port
module axi_lite_cmd_master
  import dfr_axi_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,

  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,

  output logic                            busy,
  output logic                            timeout_err,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  axi_master_state_t state, state_n;

  logic                            accept;
  logic                            aw_left;
  logic                            w_left;
  logic                            waiting;
  logic                            expiry;
  logic [CW-1:0]                   wait_count;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;

  // A channel is still owed a handshake while its VALID is up and READY is not.
  assign aw_left = M_AXI_AWVALID & ~M_AXI_AWREADY;
  assign w_left  = M_AXI_WVALID  & ~M_AXI_WREADY;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_ready && cmd_valid) begin
          accept  = 1'b1;
          state_n = cmd_write ? WR_AW_W : RD_AR;
        end
      end
      WR_AW_W: if (!aw_left && !w_left) state_n = WR_B;
      WR_B:    if (M_AXI_BVALID)        state_n = RSP;
      RD_AR:   if (M_AXI_ARREADY)       state_n = RD_R;
      RD_R:    if (M_AXI_RVALID)        state_n = RSP;
      RSP:     if (rsp_ready)           state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state, never
  // combinational paths from the slave's VALID/READY inputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= AXI_RESP_OKAY;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      state         <= state_n;
      cmd_ready     <= (state_n == IDLE);
      M_AXI_AWVALID <= (accept & cmd_write) | ((state == WR_AW_W) & aw_left);
      M_AXI_WVALID  <= (accept & cmd_write) | ((state == WR_AW_W) & w_left);
      M_AXI_BREADY  <= (state_n == WR_B);
      M_AXI_ARVALID <= (state_n == RD_AR);
      M_AXI_RREADY  <= (state_n == RD_R);
      rsp_valid     <= (state_n == RSP);
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
      end
      if (state == WR_B && M_AXI_BVALID) begin
        rsp_rdata <= '0;
        rsp_resp  <= M_AXI_BRESP;
      end
      if (state == RD_R && M_AXI_RVALID) begin
        rsp_rdata <= M_AXI_RDATA;
        rsp_resp  <= M_AXI_RRESP;
      end
    end
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign busy         = (state != IDLE);

  // Expiry only reports a stall; the transaction keeps waiting on the slave.
  assign waiting     = (state == WR_AW_W) || (state == WR_B) || (state == RD_AR) || (state == RD_R);
  assign expiry      = waiting && (wait_count == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = expiry;

  counter #(
    .WIDTH (CW)
  ) u_wait_counter (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .clr   ((state_n != state) || expiry),
    .en    (waiting),
    .count (wait_count)
  );

endmodule
